// File: rtl/ti_sbox_pkg.sv
// Shared types and helpers for the 2-share threshold-implementation S-box sequencer.
package ti_sbox_pkg;

    localparam int SHARE_W  = 4;
    localparam int N_SHARES = 2;
    localparam int WORD_W   = SHARE_W * N_SHARES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // XOR the same fresh mask into every share. With an even share count the
    // masks cancel in the XOR-sum, so the unmasked value is unchanged.
    function automatic logic [WORD_W-1:0] share_refresh(
        input logic [WORD_W-1:0]  word,
        input logic [SHARE_W-1:0] rnd
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int s = 0; s < N_SHARES; s++) begin
            res[s*SHARE_W +: SHARE_W] = word[s*SHARE_W +: SHARE_W] ^ rnd;
        end
        return res;
    endfunction

endpackage

// File: rtl/ti_share_refresh.sv
// Combinational share refresh: XORs rnd into each share when REFRESH is set,
// otherwise passes the word through untouched.
module ti_share_refresh
    import ti_sbox_pkg::*;
#(
    parameter bit REFRESH = 1'b1
) (
    input  logic [WORD_W-1:0]  i_word,
    input  logic [SHARE_W-1:0] i_rnd,
    output logic [WORD_W-1:0]  o_word
);

    generate
        if (REFRESH) begin : g_refresh
            assign o_word = share_refresh(i_word, i_rnd);
        end else begin : g_bypass
            logic [SHARE_W-1:0] w_rnd_unused;
            assign w_rnd_unused = i_rnd;
            assign o_word       = i_word;
        end
    endgenerate

endmodule

// File: rtl/ti_sbox_stage_seq.sv
// Stage sequencer for the 2-share TI 4-bit S-box: registers the masked word
// between bank passes (glitch barrier), steps stage_sel, refreshes shares.
module ti_sbox_stage_seq
    import ti_sbox_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int STAGE_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
    parameter bit REFRESH  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic [SHARE_W-1:0] rnd,
    output logic [STAGE_W-1:0] stage_sel,
    output logic [WORD_W-1:0]  comp_in,
    input  logic [WORD_W-1:0]  comp_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data
);

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WORD_W-1:0]  r_word;
    logic [WORD_W-1:0]  w_word_next;
    logic [STAGE_W-1:0] r_stage;
    logic [STAGE_W-1:0] w_stage_next;
    logic [WORD_W-1:0]  w_refreshed;

    // Bank result with fresh randomness mixed in; only consumed in RUN, so rnd
    // is effectively ignored in IDLE and DONE.
    ti_share_refresh #(
        .REFRESH (REFRESH)
    ) u_refresh (
        .i_word (comp_out),
        .i_rnd  (rnd),
        .o_word (w_refreshed)
    );

    // State, share word and stage index registers; async reset discards any
    // partially processed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
            r_stage <= w_stage_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_stage_next = r_stage;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_word_next  = in_data;
                    w_stage_next = '0;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_word_next = w_refreshed;
                if (r_stage == LAST_STAGE) begin
                    w_stage_next = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_stage_next = r_stage + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Accepting the result frees the register, so a new word can
                // be taken in the same cycle.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_word_next  = in_data;
                        w_stage_next = '0;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_stage_next = '0;
            end
        endcase
    end

    // The bank only ever sees the registered word.
    assign comp_in   = r_word;
    assign out_data  = r_word;
    assign stage_sel = r_stage;

endmodule

// File: tb/tb_ti_sbox_stage_seq.sv
// Scoreboard bench for ti_sbox_stage_seq with a behavioural coordinate bank.
module tb_ti_sbox_stage_seq;
    import ti_sbox_pkg::*;

    localparam int N_STAGES = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data = '0;
    logic [SHARE_W-1:0] rnd;
    logic [0:0]         stage_sel;
    logic [WORD_W-1:0]  comp_in;
    logic [WORD_W-1:0]  comp_out;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WORD_W-1:0]  out_data;

    logic [SHARE_W-1:0] rnd_tab [0:1];
    logic               bank_sbox = 1'b0;
    logic [0:0]         seen_stage [0:7];

    typedef struct {
        logic              xor_only;
        logic [WORD_W-1:0] val;
        int                tag;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_tx  = 0;

    ti_sbox_stage_seq #(
        .N_STAGES (N_STAGES),
        .STAGE_W  (1),
        .REFRESH  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rnd       (rnd),
        .stage_sel (stage_sel),
        .comp_in   (comp_in),
        .comp_out  (comp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // PRESENT S-box, written out by hand.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'h4 + 4'h8: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // Fresh randomness per stage, chosen by the stimulus.
    always_comb rnd = rnd_tab[stage_sel];

    // Behavioural bank: identity, or in S-box mode stage 0 replaces share0 by
    // S(a^b)^b (keeping share1 = b) and stage 1 is identity.
    always_comb begin
        comp_out = comp_in;
        if (bank_sbox && stage_sel == 1'b0)
            comp_out = {comp_in[7:4], sbox(comp_in[3:0] ^ comp_in[7:4]) ^ comp_in[7:4]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic xo, input logic [7:0] v);
        exp_t e;
        e.xor_only = xo;
        e.val      = v;
        e.tag      = n_tx;
        n_tx++;
        exp_q.push_back(e);
    endtask

    // Monitor: one pop per accepted output.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h, required no output", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("tx %0d out_data=%02h expect%s=%02h", e.tag, out_data,
                         e.xor_only ? "(xor)" : "", e.val);
                if (e.xor_only)
                    check("out_xor", 32'(out_data[3:0] ^ out_data[7:4]), 32'(e.val[3:0]));
                else
                    check("out_data", 32'(out_data), 32'(e.val));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        bit ok = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (edges < 8) seen_stage[edges] = stage_sel;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) check("out_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [3:0] m;
        rnd_tab[0] = 4'h0;
        rnd_tab[1] = 4'h0;

        // 1. reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_stage_sel", 32'(stage_sel), 32'(0));
        check("rst_comp_in", 32'(comp_in), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2. identity bank, zero randomness: latency and stage sequence
        push(1'b0, 8'hA5);
        send(8'hA5);
        wait_out(e);
        check("latency", 32'(e), 32'(2));
        check("stage_seq0", 32'(seen_stage[0]), 32'(0));
        check("stage_seq1", 32'(seen_stage[1]), 32'(1));
        @(posedge clk);
        #1;

        // 3. refresh 3 then C: 12 -> 21 -> ED, share XOR stays 3; in_valid in RUN ignored
        rnd_tab[0] = 4'h3;
        rnd_tab[1] = 4'hC;
        push(1'b0, 8'hED);
        send(8'h12);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        check("ready_in_run", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        check("stage0_word", 32'(comp_in), 32'(8'h21));
        in_valid = 1'b0;
        wait_out(e);
        check("share_xor", 32'(out_data[3:0] ^ out_data[7:4]), 32'(4'h3));
        @(posedge clk);
        #1;

        // 4. S-box bank over all 16 inputs with random masks and refresh
        bank_sbox = 1'b1;
        for (int x = 0; x < 16; x++) begin
            m          = 4'($urandom_range(0, 15));
            rnd_tab[0] = 4'($urandom_range(0, 15));
            rnd_tab[1] = 4'($urandom_range(0, 15));
            push(1'b1, {4'h0, sbox(4'(x))});
            send({m, 4'(x) ^ m});
            wait_out(e);
            @(posedge clk);
            #1;
        end
        bank_sbox  = 1'b0;
        rnd_tab[0] = 4'h0;
        rnd_tab[1] = 4'h0;

        // 5. back-pressure in DONE, then back-to-back load
        out_ready = 1'b0;
        push(1'b0, 8'h3C);
        send(8'h3C);
        wait_out(e);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_data", 32'(out_data), 32'(8'h3C));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        push(1'b0, 8'h7E);
        in_valid  = 1'b1;
        in_data   = 8'h7E;
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_in_done", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("b2b_comp_in", 32'(comp_in), 32'(8'h7E));
        check("b2b_valid_low", 32'(out_valid), 32'(0));
        wait_out(e);
        @(posedge clk);
        #1;

        // 6. reset mid-RUN at stage_sel=1 discards the word
        send(8'h55);
        @(posedge clk);
        #1;
        check("pre_abort_stage", 32'(stage_sel), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'(1));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_stage_sel", 32'(stage_sel), 32'(0));
        check("abort_comp_in", 32'(comp_in), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("post_abort_valid", 32'(out_valid), 32'(0));
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
